// File: rtl/vram_pkg.sv
// Shared widths, phase constants and return-owner tags for the VRAM time-slot scheduler.
package vram_pkg;

    localparam int unsigned VRAM_ADDR_W = 19;
    localparam int unsigned VRAM_DATA_W = 8;
    localparam int unsigned PH_W        = 2;

    localparam logic [PH_W-1:0] PH_DISP = PH_W'(0);
    localparam logic [PH_W-1:0] PH_PCK  = PH_W'(3);

    // Who owns RAM read data in the cycle after an access
    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        RD   = 2'd2
    } owner_e;

endpackage

// File: rtl/vram_slot_arb.sv
// Grant logic for the shared VRAM slots. VRAM_SCHED_RR_EN selects round-robin on
// contention; otherwise the writer always wins.
module vram_slot_arb
    import vram_pkg::*;
(
`ifdef VRAM_SCHED_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic shared,
    input  logic wr_valid,
    input  logic rd_valid,
    output logic wr_gnt_c,
    output logic rd_gnt_c
);

`ifdef VRAM_SCHED_RR_EN
    logic contend_c;
    logic rd_turn;

    assign contend_c = shared && wr_valid && rd_valid;

    // Pointer moves only when both sides actually competed for a slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_turn <= 1'b0;
        end else if (contend_c) begin
            rd_turn <= !rd_turn;
        end
    end

    always_comb begin
        wr_gnt_c = 1'b0;
        rd_gnt_c = 1'b0;
        if (contend_c) begin
            wr_gnt_c = !rd_turn;
            rd_gnt_c = rd_turn;
        end else begin
            wr_gnt_c = shared && wr_valid;
            rd_gnt_c = shared && rd_valid;
        end
    end
`else
    assign wr_gnt_c = shared && wr_valid;
    assign rd_gnt_c = shared && rd_valid && !wr_valid;
`endif

endmodule

// File: rtl/vram_sched.sv
// Time-slot scheduler for the single-port VRAM: slot 0 of each 4-cycle period is the
// display fetch, slots 1-3 are shared by writer and reader (policy via VRAM_SCHED_RR_EN).
module vram_sched
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W,
    parameter int unsigned DATA_W = VRAM_DATA_W
) (
    input  logic              sysclk,
    input  logic              rst,
    output logic              pck_en,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_vld,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_dvld,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [PH_W-1:0]   phase;
    logic              disp_slot_c;
    logic              shared_c;
    logic              wr_gnt_c;
    logic              rd_gnt_c;
    logic              disp_gnt_c;
    owner_e            owner_c;
    owner_e            tag_q;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_c;
    logic [DATA_W-1:0] wdata_q;
    logic              we_c;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            phase <= PH_DISP;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    assign pck_en = (phase == PH_PCK);

    // Grants are suppressed while reset is held so the RAM port shows its reset values
    assign disp_slot_c = !rst && (phase == PH_DISP);
    assign shared_c    = !rst && (phase != PH_DISP);
    assign disp_gnt_c  = disp_slot_c && disp_req;

    vram_slot_arb u_arb (
`ifdef VRAM_SCHED_RR_EN
        .clk      (sysclk),
        .rst      (rst),
`endif
        .shared   (shared_c),
        .wr_valid (wr_valid),
        .rd_valid (rd_valid),
        .wr_gnt_c (wr_gnt_c),
        .rd_gnt_c (rd_gnt_c)
    );

    assign wr_ready = wr_gnt_c;
    assign rd_ready = rd_gnt_c;

    // RAM port mux; address and write data hold their last granted values when idle
    always_comb begin
        owner_c = NONE;
        addr_c  = addr_q;
        wdata_c = wdata_q;
        we_c    = 1'b0;
        if (disp_gnt_c) begin
            owner_c = DISP;
            addr_c  = disp_addr;
        end else if (wr_gnt_c) begin
            addr_c  = wr_addr;
            wdata_c = wr_data;
            we_c    = 1'b1;
        end else if (rd_gnt_c) begin
            owner_c = RD;
            addr_c  = rd_addr;
        end
    end

    assign ram_addr  = addr_c;
    assign ram_wdata = wdata_c;
    assign ram_we    = we_c;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= NONE;
        end else begin
            addr_q  <= addr_c;
            wdata_q <= wdata_c;
            tag_q   <= owner_c;
        end
    end

    // Return path: the tag says whose access produced this cycle's RAM data
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            disp_vld  <= 1'b0;
            rd_data   <= '0;
            rd_dvld   <= 1'b0;
        end else begin
            disp_vld <= (tag_q == DISP);
            rd_dvld  <= (tag_q == RD);
            if (tag_q == DISP) begin
                disp_data <= ram_rdata;
            end
            if (tag_q == RD) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_sched.sv
// Self-checking bench for vram_sched: slot rules modelled per cycle, returns via a queue.
module tb_vram_sched;

    localparam int unsigned AW    = 19;
    localparam int unsigned DW    = 8;
    localparam int unsigned WORDS = 1 << AW;
    localparam int G_NONE = 0;
    localparam int G_DISP = 1;
    localparam int G_WR   = 2;
    localparam int G_RD   = 3;

    typedef struct {
        int          due;
        bit          is_rd;
        logic [DW-1:0] data;
    } ret_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pck_en;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_data;
    logic          disp_vld;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_dvld;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    bit [DW-1:0] ram     [0:WORDS-1];
    bit [DW-1:0] ref_mem [0:WORDS-1];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    ret_t pend[$];
    logic [AW-1:0] held_addr;
    logic [DW-1:0] held_wdata;
    logic [DW-1:0] exp_disp_data;
    logic [DW-1:0] exp_rd_data;
`ifdef VRAM_SCHED_RR_EN
    bit rr_rd;
`endif

    bit            dreq, wv, rv, wgot, rgot;
    logic [AW-1:0] daddr, wa, ra;
    logic [DW-1:0] wd;

    vram_sched dut (
        .sysclk    (clk),
        .rst       (rst),
        .pck_en    (pck_en),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_vld  (disp_vld),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_dvld   (rd_dvld),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port VRAM with one cycle of read latency
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, want);
        end
    endtask

    function automatic logic [AW-1:0] raddr();
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic do_reset();
        dreq = 0; wv = 0; rv = 0;
        disp_req = 0; wr_valid = 0; rd_valid = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pck_en", 32'(pck_en), 32'(0));
        chk("rst_disp_vld", 32'(disp_vld), 32'(0));
        chk("rst_disp_data", 32'(disp_data), 32'(0));
        chk("rst_rd_dvld", 32'(rd_dvld), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_ram_wdata", 32'(ram_wdata), 32'(0));
        chk("rst_wr_ready", 32'(wr_ready), 32'(0));
        chk("rst_rd_ready", 32'(rd_ready), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        pend.delete();
        held_addr = '0; held_wdata = '0;
        exp_disp_data = '0; exp_rd_data = '0;
`ifdef VRAM_SCHED_RR_EN
        rr_rd = 0;
`endif
    endtask

    // One clock cycle: drive, predict, check at negedge, advance the model
    task automatic step();
        int ph;
        int g;
        logic exp_dv, exp_rv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        ret_t r;
        disp_req = dreq; disp_addr = daddr;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra;
        ph = cyc % 4;
        g = G_NONE;
        if (ph == 0) begin
            if (dreq) g = G_DISP;
        end else if (wv && rv) begin
`ifdef VRAM_SCHED_RR_EN
            g = rr_rd ? G_RD : G_WR;
`else
            g = G_WR;
`endif
        end else if (wv) begin
            g = G_WR;
        end else if (rv) begin
            g = G_RD;
        end
        e_addr = (g == G_DISP) ? daddr : (g == G_WR) ? wa : (g == G_RD) ? ra : held_addr;
        e_wd   = (g == G_WR) ? wd : held_wdata;
        exp_dv = 0; exp_rv = 0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                if (pend[i].is_rd) begin exp_rv = 1; exp_rd_data = pend[i].data; end
                else begin exp_dv = 1; exp_disp_data = pend[i].data; end
            end
        end
        while (pend.size() > 0 && pend[0].due <= cyc) pend.delete(0);

        @(negedge clk);
        chk("pck_en", 32'(pck_en), 32'(ph == 3));
        chk("wr_ready", 32'(wr_ready), 32'(g == G_WR));
        chk("rd_ready", 32'(rd_ready), 32'(g == G_RD));
        chk("ram_we", 32'(ram_we), 32'(g == G_WR));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wd));
        chk("disp_vld", 32'(disp_vld), 32'(exp_dv));
        chk("disp_data", 32'(disp_data), 32'(exp_disp_data));
        chk("rd_dvld", 32'(rd_dvld), 32'(exp_rv));
        chk("rd_data", 32'(rd_data), 32'(exp_rd_data));

        if (g == G_WR) ref_mem[wa] = wd;
        if (g == G_DISP) begin
            r.due = cyc + 2; r.is_rd = 0; r.data = ref_mem[daddr];
            pend.push_back(r);
        end
        if (g == G_RD) begin
            r.due = cyc + 2; r.is_rd = 1; r.data = ref_mem[ra];
            pend.push_back(r);
        end
`ifdef VRAM_SCHED_RR_EN
        if (ph != 0 && wv && rv) rr_rd = !rr_rd;
`endif
        wgot = (g == G_WR);
        rgot = (g == G_RD);
        held_addr = e_addr;
        held_wdata = e_wd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = DW'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[16] = 8'hA5; ref_mem[16] = 8'hA5;
        daddr = '0; wa = '0; ra = '0; wd = '0;
        #1;
        do_reset();

        // Idle: pixel strobe cadence, no writes
        repeat (12) step();

        // Display fetch of a known pixel
        dreq = 1; daddr = AW'(16);
        repeat (12) step();
        dreq = 0;

        // Write then read of the same address under contention
        wv = 1; wa = AW'(19'h12345); wd = 8'h3C;
        rv = 1; ra = AW'(19'h12345);
        for (int k = 0; k < 8; k++) begin
            step();
            if (wgot) wv = 0;
            if (rgot) rv = 0;
        end
        chk("raw_rd_data", 32'(rd_data), 32'(8'h3C));

        // Both requesters saturated
        wv = 1; wa = raddr(); wd = DW'($urandom);
        rv = 1; ra = raddr();
        repeat (16) begin
            step();
            if (wgot) begin wa = raddr(); wd = DW'($urandom); end
            if (rgot) ra = raddr();
        end

        // Random traffic honouring the hold-until-ready rule
        repeat (400) begin
            if (!wv && $urandom_range(0, 2) == 0) begin wv = 1; wa = raddr(); wd = DW'($urandom); end
            if (!rv && $urandom_range(0, 2) == 0) begin rv = 1; ra = raddr(); end
            dreq = ($urandom_range(0, 1) == 1);
            daddr = raddr();
            step();
            if (wgot) wv = 0;
            if (rgot) rv = 0;
        end
        dreq = 0;
        for (int k = 0; k < 12 && (wv || rv); k++) begin
            step();
            if (wgot) wv = 0;
            if (rgot) rv = 0;
        end
        chk("drain_done", 32'(wv || rv), 32'(0));

        // Reset one cycle after a read grant: the read must never return
        rv = 1; ra = AW'(5);
        for (int k = 0; k < 8 && rv; k++) begin
            step();
            if (rgot) rv = 0;
        end
        do_reset();
        repeat (8) step();

        repeat (100) begin
            if (!wv && $urandom_range(0, 1) == 0) begin wv = 1; wa = raddr(); wd = DW'($urandom); end
            if (!rv && $urandom_range(0, 1) == 0) begin rv = 1; ra = raddr(); end
            dreq = ($urandom_range(0, 3) != 0);
            daddr = raddr();
            step();
            if (wgot) wv = 0;
            if (rgot) rv = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
